// File: rtl/crank_decoder.sv
// crank_decoder: missing-tooth crank wheel decoder producing sync state, per-tooth trigger and phase data
module crank_decoder #(
  parameter int TOOTH_POSITIONS = 60,
  parameter int MISSING_TEETH = 1,
  parameter int QUANTA_PER_TOOTH = 256,
  parameter logic [31:0] STALL_CYCLES = 32'd50000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tooth_in,
  output logic        trigger,
  output logic [15:0] eng_phase,
  output logic [15:0] next_tooth_width,
  output logic [31:0] tooth_period,
  output logic        synced,
  output logic        sync_loss
);
  localparam int IW = $clog2(TOOTH_POSITIONS);
  localparam logic [IW-1:0] LAST = IW'(TOOTH_POSITIONS - MISSING_TEETH);
  localparam logic [IW-1:0] LAST1 = IW'(TOOTH_POSITIONS - MISSING_TEETH - 1);
  localparam logic [15:0] QW = 16'(QUANTA_PER_TOOTH);
  localparam logic [15:0] GAP_W = 16'((MISSING_TEETH + 1) * QUANTA_PER_TOOTH);
  localparam logic [2:0] GAP_K = 3'(2 * MISSING_TEETH + 1);
  typedef enum logic [1:0] {SEEK, PRESYNC, SYNCED} state_t;
  state_t state;
  logic s1, s2, s2_d, edge_r;
  logic [31:0] cnt, last_period;
  logic [IW-1:0] idx, nxt, idx_n;
  logic [1:0] seen;
  logic gap_eff, noise, stall, take, ok, good, fire, drop, upd;
  always_comb begin
    gap_eff = seen == 2'd2 && ({3'b0, cnt} << 1) > (35'(last_period) * 35'(GAP_K));
    noise = state == SYNCED && cnt < {2'b0, last_period[31:2]};
    stall = cnt == STALL_CYCLES;
    take = edge_r && !noise;
    nxt = idx + IW'(1);
    ok = nxt == LAST;
    good = gap_eff == ok;
    idx_n = gap_eff ? '0 : nxt;
    fire = take && !stall && good && (state == SYNCED || (state == PRESYNC && gap_eff));
    drop = state == SYNCED && (stall || (take && !good));
    upd = take && !stall && !gap_eff;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      {s1, s2, s2_d, edge_r, trigger, sync_loss, synced} <= '0;
      state <= SEEK;
      cnt <= '0;
      last_period <= '0;
      idx <= '0;
      seen <= '0;
      eng_phase <= '0;
      next_tooth_width <= '0;
      tooth_period <= '0;
    end else begin
      s1 <= tooth_in;
      s2 <= s1;
      s2_d <= s2;
      edge_r <= s2 & ~s2_d;
      cnt <= take ? 32'd1 : cnt + {31'd0, ~&cnt};
      trigger <= fire;
      sync_loss <= drop;
      synced <= fire || (synced && !drop);
      if (upd) last_period <= cnt;
      if (stall) begin
        state <= SEEK;
        seen <= take ? 2'd1 : 2'd0;
        idx <= '0;
        eng_phase <= '0;
        next_tooth_width <= '0;
        tooth_period <= '0;
      end else if (take) begin
        if (seen != 2'd2) seen <= seen + 2'd1;
        if (upd && (state != SYNCED || fire)) tooth_period <= cnt;
        idx <= state == SEEK ? '0 : idx_n;
        if (fire) begin
          eng_phase <= 16'(idx_n) * QW;
          next_tooth_width <= idx_n == LAST1 ? GAP_W : QW;
        end
        case (state)
          SEEK: if (gap_eff) state <= PRESYNC;
          PRESYNC: if (ok) state <= gap_eff ? SYNCED : SEEK;
          default: if (!good) state <= SEEK;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_crank_decoder.sv
// tb_crank_decoder: directed bench for the 60-1 crank decoder (100-clk teeth keep runtime short)
module tb_crank_decoder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tooth_in = 1'b0;
  logic trigger, synced, sync_loss;
  logic [15:0] eng_phase, next_tooth_width;
  logic [31:0] tooth_period;
  int checks = 0, failures = 0;
  int cyc = 0, pos = 0, last_rise = 0;
  int trig_n = 0, loss_n = 0, last_trig = 0, last_loss = 0;
  logic [15:0] ph_q[$], nw_q[$];
  logic [31:0] tp_q[$];

  crank_decoder #(.STALL_CYCLES(32'd5000)) dut (
    .clk(clk), .reset(reset), .tooth_in(tooth_in), .trigger(trigger),
    .eng_phase(eng_phase), .next_tooth_width(next_tooth_width),
    .tooth_period(tooth_period), .synced(synced), .sync_loss(sync_loss)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (trigger) begin
      trig_n = trig_n + 1;
      last_trig = cyc;
      ph_q.push_back(eng_phase);
      nw_q.push_back(next_tooth_width);
      tp_q.push_back(tooth_period);
    end
    if (sync_loss) begin
      loss_n = loss_n + 1;
      last_loss = cyc;
    end
  end

  task automatic tooth(input int p);
    tooth_in = 1'b1;
    last_rise = cyc + 1;
    repeat (5) @(negedge clk);
    tooth_in = 1'b0;
    repeat (p - 5) @(negedge clk);
  endtask

  task automatic next_tooth();
    tooth(pos == 58 ? 200 : 100);
    pos = (pos + 1) % 59;
  endtask

  task automatic run_rev();
    for (int i = 0; i < 59; i++) next_tooth();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({trigger, synced, sync_loss} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=000", {trigger, synced, sync_loss});
    end
    checks++;
    if (eng_phase !== 16'd0) begin
      failures++;
      $display("FAIL reset_phase got=%0d exp=0", eng_phase);
    end
    checks++;
    if (next_tooth_width !== 16'd0) begin
      failures++;
      $display("FAIL reset_width got=%0d exp=0", next_tooth_width);
    end
    checks++;
    if (tooth_period !== 32'd0) begin
      failures++;
      $display("FAIL reset_period got=%0d exp=0", tooth_period);
    end
    reset = 1'b0;
  endtask

  task automatic test_sync();
    int n0;
    pos = 0;
    run_rev();
    run_rev();
    #1;
    checks++;
    if (synced !== 1'b0) begin
      failures++;
      $display("FAIL sync_early got=%b exp=0", synced);
    end
    ph_q.delete();
    nw_q.delete();
    tp_q.delete();
    n0 = trig_n;
    run_rev();
    #1;
    checks++;
    if (trig_n - n0 !== 59) begin
      failures++;
      $display("FAIL sync_trig_count got=%0d exp=59", trig_n - n0);
    end
    for (int i = 0; i < 59 && i < ph_q.size(); i++) begin
      logic [15:0] e_ph, e_nw;
      e_ph = 16'(i * 256);
      e_nw = i == 58 ? 16'd512 : 16'd256;
      checks++;
      if (ph_q[i] !== e_ph || nw_q[i] !== e_nw || tp_q[i] !== 32'd100) begin
        failures++;
        $display("FAIL sync_trig%0d got phase=%0d width=%0d period=%0d exp phase=%0d width=%0d period=100",
                 i, ph_q[i], nw_q[i], tp_q[i], e_ph, e_nw);
      end
    end
    checks++;
    if (synced !== 1'b1) begin
      failures++;
      $display("FAIL sync_synced got=%b exp=1", synced);
    end
    checks++;
    if (loss_n !== 0) begin
      failures++;
      $display("FAIL sync_no_loss got=%0d exp=0", loss_n);
    end
  endtask

  task automatic test_latency();
    int n0, p;
    n0 = trig_n;
    p = pos;
    next_tooth();
    #1;
    checks++;
    if (trig_n - n0 !== 1) begin
      failures++;
      $display("FAIL latency_count got=%0d exp=1", trig_n - n0);
    end
    checks++;
    if (last_trig !== last_rise + 3) begin
      failures++;
      $display("FAIL latency_cycle got=%0d exp=%0d", last_trig - last_rise, 3);
    end
    checks++;
    if (eng_phase !== 16'(p * 256)) begin
      failures++;
      $display("FAIL latency_phase got=%0d exp=%0d", eng_phase, p * 256);
    end
  endtask

  task automatic test_glitch();
    int n0, l0, p;
    n0 = trig_n;
    l0 = loss_n;
    p = pos;
    tooth_in = 1'b1;
    repeat (5) @(negedge clk);
    tooth_in = 1'b0;
    repeat (5) @(negedge clk);
    tooth_in = 1'b1;
    repeat (2) @(negedge clk);
    tooth_in = 1'b0;
    repeat (88) @(negedge clk);
    pos = pos + 1;
    next_tooth();
    #1;
    checks++;
    if (trig_n - n0 !== 2) begin
      failures++;
      $display("FAIL glitch_count got=%0d exp=2", trig_n - n0);
    end
    checks++;
    if (eng_phase !== 16'((p + 1) * 256)) begin
      failures++;
      $display("FAIL glitch_phase got=%0d exp=%0d", eng_phase, (p + 1) * 256);
    end
    checks++;
    if (synced !== 1'b1) begin
      failures++;
      $display("FAIL glitch_synced got=%b exp=1", synced);
    end
    checks++;
    if (loss_n !== l0) begin
      failures++;
      $display("FAIL glitch_loss got=%0d exp=%0d", loss_n, l0);
    end
  endtask

  task automatic test_extra_tooth();
    int n0, l0, n1;
    while (pos != 58) next_tooth();
    n0 = trig_n;
    l0 = loss_n;
    tooth(100);
    tooth(100);
    pos = 0;
    #1;
    checks++;
    if (trig_n - n0 !== 1) begin
      failures++;
      $display("FAIL extra_trig_count got=%0d exp=1", trig_n - n0);
    end
    checks++;
    if (eng_phase !== 16'd14848 || next_tooth_width !== 16'd512) begin
      failures++;
      $display("FAIL extra_last_tooth got phase=%0d width=%0d exp phase=14848 width=512", eng_phase, next_tooth_width);
    end
    checks++;
    if (loss_n - l0 !== 1) begin
      failures++;
      $display("FAIL extra_loss_count got=%0d exp=1", loss_n - l0);
    end
    checks++;
    if (last_loss !== last_rise + 3) begin
      failures++;
      $display("FAIL extra_loss_cycle got=%0d exp=3", last_loss - last_rise);
    end
    checks++;
    if (synced !== 1'b0) begin
      failures++;
      $display("FAIL extra_synced got=%b exp=0", synced);
    end
    run_rev();
    #1;
    checks++;
    if (synced !== 1'b0) begin
      failures++;
      $display("FAIL extra_seek_rev got=%b exp=0", synced);
    end
    run_rev();
    #1;
    checks++;
    if (synced !== 1'b0) begin
      failures++;
      $display("FAIL extra_presync_rev got=%b exp=0", synced);
    end
    n1 = trig_n;
    next_tooth();
    #1;
    checks++;
    if (synced !== 1'b1 || eng_phase !== 16'd0 || trig_n - n1 !== 1) begin
      failures++;
      $display("FAIL extra_resync got synced=%b phase=%0d trig=%0d exp synced=1 phase=0 trig=1", synced, eng_phase, trig_n - n1);
    end
  endtask

  task automatic test_reset_mid();
    int n0, l0;
    next_tooth();
    next_tooth();
    n0 = trig_n;
    l0 = loss_n;
    tooth_in = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    tooth_in = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if ({trigger, synced, sync_loss} !== 3'b000) begin
      failures++;
      $display("FAIL rstmid_flags got=%b exp=000", {trigger, synced, sync_loss});
    end
    checks++;
    if (eng_phase !== 16'd0 || next_tooth_width !== 16'd0 || tooth_period !== 32'd0) begin
      failures++;
      $display("FAIL rstmid_data got phase=%0d width=%0d period=%0d exp all 0", eng_phase, next_tooth_width, tooth_period);
    end
    repeat (4) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (trig_n !== n0 || loss_n !== l0) begin
      failures++;
      $display("FAIL rstmid_pulses got trig=%0d loss=%0d exp trig=%0d loss=%0d", trig_n, loss_n, n0, l0);
    end
    pos = 0;
    run_rev();
    #1;
    checks++;
    if (synced !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_rev1 got=%b exp=0", synced);
    end
    run_rev();
    #1;
    checks++;
    if (synced !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_rev2 got=%b exp=0", synced);
    end
    next_tooth();
    #1;
    checks++;
    if (synced !== 1'b1 || eng_phase !== 16'd0) begin
      failures++;
      $display("FAIL rstmid_resync got synced=%b phase=%0d exp synced=1 phase=0", synced, eng_phase);
    end
  endtask

  task automatic test_stall();
    int n0, l0;
    next_tooth();
    n0 = trig_n;
    l0 = loss_n;
    tooth_in = 1'b1;
    repeat (5) @(negedge clk);
    tooth_in = 1'b0;
    for (int i = 0; i < 6000 && loss_n == l0; i++) begin
      @(negedge clk);
      #1;
    end
    checks++;
    if (trig_n - n0 !== 1) begin
      failures++;
      $display("FAIL stall_last_trig got=%0d exp=1", trig_n - n0);
    end
    checks++;
    if (loss_n - l0 !== 1) begin
      failures++;
      $display("FAIL stall_loss_count got=%0d exp=1", loss_n - l0);
    end
    checks++;
    if (last_loss - last_trig !== 5000) begin
      failures++;
      $display("FAIL stall_delay got=%0d exp=5000", last_loss - last_trig);
    end
    checks++;
    if ({trigger, synced} !== 2'b00) begin
      failures++;
      $display("FAIL stall_flags got=%b exp=00", {trigger, synced});
    end
    checks++;
    if (eng_phase !== 16'd0 || next_tooth_width !== 16'd0 || tooth_period !== 32'd0) begin
      failures++;
      $display("FAIL stall_data got phase=%0d width=%0d period=%0d exp all 0", eng_phase, next_tooth_width, tooth_period);
    end
    @(negedge clk);
    #1;
    checks++;
    if (sync_loss !== 1'b0) begin
      failures++;
      $display("FAIL stall_pulse_width got=%b exp=0", sync_loss);
    end
  endtask

  initial begin
    test_reset();
    test_sync();
    test_latency();
    test_glitch();
    test_extra_tooth();
    test_reset_mid();
    test_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
